ffcp_rx_window_sack: RTL and testbench

FFCP_RX_WINDOW_SACK -- requirements
Module: ffcp_rx_window_sack

---
 rtl/ffcp_rx_window_sack.sv | 116 +++++++++++
 tb/tb_ffcp_rx_window_sack.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ffcp_rx_window_sack.sv
// FFCP receive window: tracks received indices around the queue head,
// advances the cumulative ack and emits coalesced selective acks.
module ffcp_rx_window_sack #(
    parameter int INDEX_W      = 6,
    parameter int WINDOW_LEN   = 8,
    parameter int ACK_COALESCE = 4,
    parameter int ACK_TIMEOUT  = 500000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  syn,
    input  logic                  inclk,
    input  logic [INDEX_W-1:0]    in_index,
    input  logic                  downstream_done,
    output logic                  outclk,
    output logic [INDEX_W-1:0]    out_index,
    output logic [WINDOW_LEN-1:0] out_sack,
    output logic [15:0]           drop_cnt
);

    localparam int N  = 1 << INDEX_W;
    localparam int PW = $clog2(ACK_COALESCE + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [PW-1:0] PMAX = PW'(ACK_COALESCE);
    localparam logic [TW-1:0] TMAX = TW'(ACK_TIMEOUT);
    localparam logic [INDEX_W-1:0] WIN = INDEX_W'(WINDOW_LEN);
    localparam logic [INDEX_W-1:0] STALE_LO = INDEX_W'(N - WINDOW_LEN);

    logic [N-1:0]         received;
    logic [INDEX_W-1:0]   head;
    logic [INDEX_W-1:0]   offset;
    logic [PW-1:0]        pend_cnt;
    logic [TW-1:0]        timer;
    logic                 force_ack;
    logic                 downstream_rdy;
    logic                 head_set;
    logic                 in_window;
    logic                 stale;
    logic                 ack_due;

    assign offset    = in_index - head;
    assign in_window = offset < WIN;
    assign stale     = offset >= STALE_LO;
    assign head_set  = received[head];
    assign ack_due   = force_ack || (pend_cnt >= PMAX) || (timer == TMAX);

    // An ack is never sent while the head slot is filled: advance first.
    assign outclk = ack_due && !head_set && !inclk && downstream_rdy
                    && !rst && !syn;

    assign out_index = rst ? '0 : head;

    always_comb begin
        out_sack = '0;
        if (!rst) begin
            for (int i = 0; i < WINDOW_LEN; i++) begin
                out_sack[i] = received[head + INDEX_W'(i + 1)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            received       <= '0;
            head           <= '0;
            pend_cnt       <= '0;
            timer          <= '0;
            force_ack      <= 1'b0;
            downstream_rdy <= 1'b1;
            drop_cnt       <= '0;
        end else begin
            if (outclk) begin
                downstream_rdy <= 1'b0;
            end else if (downstream_done) begin
                downstream_rdy <= 1'b1;
            end

            if (syn) begin
                received  <= '0;
                head      <= INDEX_W'(1);
                pend_cnt  <= '0;
                timer     <= '0;
                force_ack <= 1'b1;
            end else begin
                if (inclk) begin
                    if (in_window) begin
                        received[in_index] <= 1'b1;
                    end else if (stale) begin
                        force_ack <= 1'b1;
                    end else if (drop_cnt != 16'hFFFF) begin
                        drop_cnt <= drop_cnt + 16'd1;
                    end
                end else if (head_set) begin
                    received[head] <= 1'b0;
                    head           <= head + INDEX_W'(1);
                    if (pend_cnt != PMAX) begin
                        pend_cnt <= pend_cnt + PW'(1);
                    end
                end

                if (outclk) begin
                    pend_cnt  <= '0;
                    force_ack <= 1'b0;
                    timer     <= '0;
                end else if (pend_cnt != '0 || force_ack) begin
                    if (timer != TMAX) begin
                        timer <= timer + TW'(1);
                    end
                end else begin
                    timer <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ffcp_rx_window_sack.sv
// Randomized and directed bench for ffcp_rx_window_sack against a
// cycle-level behavioural model of the receive window.
module tb_ffcp_rx_window_sack;

    localparam int IW  = 6;
    localparam int WL  = 8;
    localparam int CO  = 4;
    localparam int TO  = 16;
    localparam int MOD = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          syn = 1'b0;
    logic          inclk = 1'b0;
    logic [IW-1:0] in_index = '0;
    logic          downstream_done = 1'b0;
    logic          outclk;
    logic [IW-1:0] out_index;
    logic [WL-1:0] out_sack;
    logic [15:0]   drop_cnt;

    ffcp_rx_window_sack #(
        .INDEX_W(IW),
        .WINDOW_LEN(WL),
        .ACK_COALESCE(CO),
        .ACK_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .syn(syn),
        .inclk(inclk),
        .in_index(in_index),
        .downstream_done(downstream_done),
        .outclk(outclk),
        .out_index(out_index),
        .out_sack(out_sack),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    bit m_rcv[MOD];
    int m_head  = 0;
    int m_pend  = 0;
    int m_timer = 0;
    bit m_force = 0;
    bit m_rdy   = 1;
    int m_drops = 0;

    // observed ack statistics
    int n_ack     = 0;
    int last_idx  = 0;
    int last_sack = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int offs(input int idx);
        return (idx - m_head + MOD) % MOD;
    endfunction

    function automatic int model_sack();
        int v = 0;
        for (int i = 0; i < WL; i++)
            if (m_rcv[(m_head + 1 + i) % MOD]) v |= (1 << i);
        return v;
    endfunction

    task automatic model_reset();
        foreach (m_rcv[k]) m_rcv[k] = 0;
        m_head = 0; m_pend = 0; m_timer = 0;
        m_force = 0; m_rdy = 1; m_drops = 0;
    endtask

    task automatic step(input bit r, input bit s, input bit ic,
                        input int idx, input bit d);
        bit due, exp_out, active;
        int o;
        rst = r; syn = s; inclk = ic;
        in_index = IW'(idx); downstream_done = d;
        @(negedge clk);
        due = m_force || (m_pend >= CO) || (m_timer == TO);
        exp_out = due && !m_rcv[m_head] && !ic && m_rdy && !r && !s;
        check("outclk", 32'(outclk), 32'(exp_out));
        check("out_index", 32'(out_index), r ? 32'd0 : 32'(m_head));
        check("out_sack", 32'(out_sack), r ? 32'd0 : 32'(model_sack()));
        if (!r) check("drop_cnt", 32'(drop_cnt), 32'(m_drops));
        if (outclk) begin
            n_ack++;
            last_idx  = int'(out_index);
            last_sack = int'(out_sack);
        end
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else begin
            if (exp_out) m_rdy = 0;
            else if (d) m_rdy = 1;
            if (s) begin
                foreach (m_rcv[k]) m_rcv[k] = 0;
                m_head = 1; m_pend = 0; m_timer = 0; m_force = 1;
            end else begin
                active = (m_pend != 0) || m_force;
                if (ic) begin
                    o = offs(idx);
                    if (o < WL) m_rcv[idx % MOD] = 1;
                    else if (o >= MOD - WL) m_force = 1;
                    else if (m_drops < 65535) m_drops++;
                end else if (m_rcv[m_head]) begin
                    m_rcv[m_head] = 0;
                    m_head = (m_head + 1) % MOD;
                    if (m_pend < CO) m_pend++;
                end
                if (exp_out) begin
                    m_pend = 0; m_force = 0; m_timer = 0;
                end else if (active) begin
                    if (m_timer < TO) m_timer++;
                end else begin
                    m_timer = 0;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic rx(input int idx);
        step(0, 0, 1, idx, 0);
    endtask

    task automatic done();
        step(0, 0, 0, 0, 1);
    endtask

    task automatic flush();
        idle(20); done(); idle(20); done();
    endtask

    task automatic restart();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
    endtask

    int base;
    int idx;

    initial begin
        model_reset();

        // reset, syn, immediate ack, no repeat before done
        restart();
        base = n_ack;
        idle(1);
        check("syn_ack", 32'(n_ack - base), 32'd1);
        check("syn_ack_idx", 32'(last_idx), 32'd1);
        check("syn_ack_sack", 32'(last_sack), 32'd0);
        idle(5);
        check("syn_no_repeat", 32'(n_ack - base), 32'd1);
        done();

        // in-order burst coalesced into one ack
        base = n_ack;
        rx(1); rx(2); rx(3); rx(4);
        idle(8);
        check("burst_acks", 32'(n_ack - base), 32'd1);
        check("burst_idx", 32'(last_idx), 32'd5);
        check("burst_sack", 32'(last_sack), 32'd0);
        done();

        // holes: nothing pending, then stale packet forces a sack
        base = n_ack;
        rx(7); rx(9);
        idle(20);
        check("hole_no_ack", 32'(n_ack - base), 32'd0);
        rx(4);
        idle(2);
        check("stale_ack", 32'(n_ack - base), 32'd1);
        check("stale_idx", 32'(last_idx), 32'd5);
        check("stale_sack", 32'(last_sack), 32'h0A);
        done();

        // walk head to 60, then wrap
        restart();
        idle(1);
        done();
        for (int j = 1; j < 60; j++) begin
            step(0, 0, 1, j, 1);
            step(0, 0, 0, 0, 1);
        end
        flush();
        check("head60", 32'(out_index), 32'd60);
        rx(62); rx(63); rx(0); rx(1); rx(60); rx(61);
        idle(8);
        check("wrap_head", 32'(out_index), 32'd2);
        rx(13);
        idle(1);
        check("drop_one", 32'(drop_cnt), 32'd1);

        // ack and done in the same cycle keep the transmitter busy
        flush();
        base = n_ack;
        rx(1);
        done();
        check("same_cycle_ack", 32'(n_ack - base), 32'd1);
        rx(1);
        idle(6);
        check("busy_hold", 32'(n_ack - base), 32'd1);
        done();
        idle(1);
        check("busy_release", 32'(n_ack - base), 32'd2);

        // reset mid-operation discards pending work
        flush();
        rx(2); rx(3); rx(4); rx(8);
        idle(3);
        step(1, 0, 0, 0, 0);
        base = n_ack;
        idle(16);
        check("rst_quiet", 32'(n_ack - base), 32'd0);
        check("rst_index", 32'(out_index), 32'd0);
        check("rst_sack", 32'(out_sack), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);

        // randomized traffic around the head
        restart();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0)
                idx = int'($urandom_range(0, MOD - 1));
            else
                idx = (m_head + MOD - 6 + int'($urandom_range(0, 20))) % MOD;
            step($urandom_range(0, 399) == 0,
                 $urandom_range(0, 149) == 0,
                 $urandom_range(0, 9) < 4,
                 idx,
                 $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
